// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the memory access unit and the memory.
// Latency: none, wires only.
// Backpressure: the memory holds off a request by keeping mem_gnt low.
// Ports: master drives mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb.
//        slave drives mem_gnt/mem_rvalid/mem_rdata.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: retires ALU ops and performs loads/stores over a req/gnt/rvalid bus.
// Latency: ALU ops and faulting accesses 1 cycle; loads/stores >= 3 cycles, timeout after RESP_TIMEOUT.
// Backpressure: stall_to_ex_stage is high whenever a bus access is in flight (state not IDLE).
// Ports: clk/rst (async active-low); *_from_ex_stage instruction inputs; bus (data-bus master);
//        *_to_wb_stage, mem_fault, fault_cause registered one-cycle retirement outputs.
module mem_access_unit #(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_from_ex_stage,
  input  logic                     regfile_write_signal_from_ex_stage,
  input  logic                     mem_read_from_ex_stage,
  input  logic                     mem_write_from_ex_stage,
  input  logic [2:0]               funct3_from_ex_stage,
  input  logic [4:0]               rd_index_from_ex_stage,
  input  logic [31:0]              inst_from_ex_stage,
  input  logic [31:0]              inst_addr_from_ex_stage,
  input  logic [31:0]              alu_result_from_ex_stage,
  input  logic [31:0]              store_data_from_ex_stage,
  output logic                     stall_to_ex_stage,
  mem_access_unit_if.master        bus,
  output logic                     regfile_write_signal_to_wb_stage,
  output logic [4:0]               rd_index_to_wb_stage,
  output logic [31:0]              inst_to_wb_stage,
  output logic [31:0]              inst_addr_to_wb_stage,
  output logic [31:0]              rd_reg_content_to_wb_stage,
  output logic                     mem_fault,
  output logic [1:0]               fault_cause
);

  localparam int CW = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(RESP_TIMEOUT);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_FUNCT3   = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            ld_q;
  logic            wr_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;
  logic [31:0]     inst_q;
  logic [31:0]     pc_q;

  logic            is_mem;
  logic            is_load;
  logic            bad_f3;
  logic            misal;
  logic [31:0]     st_wdata;
  logic [3:0]      st_wstrb;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_data;

  // Request decode for the instruction presented by execute.
  always_comb begin
    is_mem  = mem_read_from_ex_stage | mem_write_from_ex_stage;
    is_load = mem_read_from_ex_stage;  // read wins when both are set
    bad_f3  = (funct3_from_ex_stage == 3'b011) || (funct3_from_ex_stage == 3'b110) ||
              (funct3_from_ex_stage == 3'b111) || (!is_load && funct3_from_ex_stage[2]);
    misal   = ((funct3_from_ex_stage[1:0] == 2'b01) && alu_result_from_ex_stage[0]) ||
              ((funct3_from_ex_stage[1:0] == 2'b10) && (alu_result_from_ex_stage[1:0] != 2'b00));

    st_wdata = store_data_from_ex_stage;
    st_wstrb = 4'b1111;
    case (funct3_from_ex_stage[1:0])
      2'b00: begin
        st_wdata = {4{store_data_from_ex_stage[7:0]}};
        st_wstrb = 4'b0001 << alu_result_from_ex_stage[1:0];
      end
      2'b01: begin
        st_wdata = {2{store_data_from_ex_stage[15:0]}};
        st_wstrb = alu_result_from_ex_stage[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Lane extraction of returned read data using the captured offset.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                            <= IDLE;
      cnt                              <= '0;
      ld_q                             <= 1'b0;
      wr_q                             <= 1'b0;
      f3_q                             <= 3'd0;
      off_q                            <= 2'd0;
      rd_q                             <= 5'd0;
      inst_q                           <= 32'd0;
      pc_q                             <= 32'd0;
      stall_to_ex_stage                <= 1'b0;
      bus.mem_req                      <= 1'b0;
      bus.mem_we                       <= 1'b0;
      bus.mem_addr                     <= 32'd0;
      bus.mem_wdata                    <= 32'd0;
      bus.mem_wstrb                    <= 4'd0;
      regfile_write_signal_to_wb_stage <= 1'b0;
      rd_index_to_wb_stage             <= 5'd0;
      inst_to_wb_stage                 <= 32'd0;
      inst_addr_to_wb_stage            <= 32'd0;
      rd_reg_content_to_wb_stage       <= 32'd0;
      mem_fault                        <= 1'b0;
      fault_cause                      <= 2'b00;
    end else begin
      // Writeback outputs are single-cycle pulses; idle value is all zero.
      regfile_write_signal_to_wb_stage <= 1'b0;
      rd_index_to_wb_stage             <= 5'd0;
      inst_to_wb_stage                 <= 32'd0;
      inst_addr_to_wb_stage            <= 32'd0;
      rd_reg_content_to_wb_stage       <= 32'd0;
      mem_fault                        <= 1'b0;
      fault_cause                      <= 2'b00;

      case (state)
        IDLE: begin
          if (valid_from_ex_stage) begin
            rd_index_to_wb_stage  <= rd_index_from_ex_stage;
            inst_to_wb_stage      <= inst_from_ex_stage;
            inst_addr_to_wb_stage <= inst_addr_from_ex_stage;
            if (!is_mem) begin
              regfile_write_signal_to_wb_stage <= regfile_write_signal_from_ex_stage;
              rd_reg_content_to_wb_stage       <= alu_result_from_ex_stage;
            end else if (bad_f3 || misal) begin
              // Undefined width is reported ahead of alignment.
              rd_reg_content_to_wb_stage <= alu_result_from_ex_stage;
              mem_fault                  <= 1'b1;
              fault_cause                <= bad_f3 ? CAUSE_FUNCT3 : CAUSE_MISALIGN;
            end else begin
              // Legal access: suppress the immediate retirement and go to the bus.
              rd_index_to_wb_stage  <= 5'd0;
              inst_to_wb_stage      <= 32'd0;
              inst_addr_to_wb_stage <= 32'd0;
              state             <= REQ;
              stall_to_ex_stage <= 1'b1;
              cnt               <= CW'(1);
              ld_q              <= is_load;
              wr_q              <= regfile_write_signal_from_ex_stage;
              f3_q              <= funct3_from_ex_stage;
              off_q             <= alu_result_from_ex_stage[1:0];
              rd_q              <= rd_index_from_ex_stage;
              inst_q            <= inst_from_ex_stage;
              pc_q              <= inst_addr_from_ex_stage;
              bus.mem_req       <= 1'b1;
              bus.mem_we        <= !is_load;
              bus.mem_addr      <= {alu_result_from_ex_stage[31:2], 2'b00};
              bus.mem_wdata     <= is_load ? 32'd0 : st_wdata;
              bus.mem_wstrb     <= is_load ? 4'd0 : st_wstrb;
            end
          end
        end

        REQ, WAIT: begin
          if (state == WAIT && bus.mem_rvalid) begin
            state                            <= IDLE;
            stall_to_ex_stage                <= 1'b0;
            cnt                              <= '0;
            regfile_write_signal_to_wb_stage <= ld_q & wr_q;
            rd_index_to_wb_stage             <= rd_q;
            inst_to_wb_stage                 <= inst_q;
            inst_addr_to_wb_stage            <= pc_q;
            rd_reg_content_to_wb_stage       <= ld_q ? ld_data : 32'd0;
          end else if (cnt == TMO) begin
            state                 <= IDLE;
            stall_to_ex_stage     <= 1'b0;
            cnt                   <= '0;
            bus.mem_req           <= 1'b0;
            bus.mem_we            <= 1'b0;
            bus.mem_wdata         <= 32'd0;
            bus.mem_wstrb         <= 4'd0;
            rd_index_to_wb_stage  <= rd_q;
            inst_to_wb_stage      <= inst_q;
            inst_addr_to_wb_stage <= pc_q;
            mem_fault             <= 1'b1;
            fault_cause           <= CAUSE_TIMEOUT;
          end else begin
            cnt <= cnt + CW'(1);
            if (state == REQ && bus.mem_gnt) begin
              state         <= WAIT;
              bus.mem_req   <= 1'b0;
              bus.mem_we    <= 1'b0;
              bus.mem_wdata <= 32'd0;
              bus.mem_wstrb <= 4'd0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with RESP_TIMEOUT=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_mem_access_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid, wr_sig, mrd, mwr;
  logic [2:0]  f3;
  logic [4:0]  rd_i;
  logic [31:0] inst_i, pc_i, alu, sd;
  logic        stall;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_inst, wb_pc, wb_dat;
  logic        fault;
  logic [1:0]  cause;

  int checks = 0;
  int errors = 0;

  mem_access_unit_if bus();

  mem_access_unit #(.RESP_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .valid_from_ex_stage(valid),
    .regfile_write_signal_from_ex_stage(wr_sig),
    .mem_read_from_ex_stage(mrd),
    .mem_write_from_ex_stage(mwr),
    .funct3_from_ex_stage(f3),
    .rd_index_from_ex_stage(rd_i),
    .inst_from_ex_stage(inst_i),
    .inst_addr_from_ex_stage(pc_i),
    .alu_result_from_ex_stage(alu),
    .store_data_from_ex_stage(sd),
    .stall_to_ex_stage(stall),
    .bus(bus.master),
    .regfile_write_signal_to_wb_stage(wb_we),
    .rd_index_to_wb_stage(wb_rd),
    .inst_to_wb_stage(wb_inst),
    .inst_addr_to_wb_stage(wb_pc),
    .rd_reg_content_to_wb_stage(wb_dat),
    .mem_fault(fault),
    .fault_cause(cause)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m_rd, input logic m_wr, input logic [2:0] f,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d);
    valid  = 1'b1;
    wr_sig = 1'b1;
    mrd    = m_rd;
    mwr    = m_wr;
    f3     = f;
    rd_i   = rd;
    alu    = a;
    sd     = d;
    inst_i = 32'hC0DE_0000 | {16'd0, a[15:0]};
    pc_i   = 32'h8000_0000 + a;
  endtask

  task automatic idle_in;
    valid = 1'b0; wr_sig = 1'b0; mrd = 1'b0; mwr = 1'b0;
    f3 = 3'd0; rd_i = 5'd0; alu = 32'd0; sd = 32'd0; inst_i = 32'd0; pc_i = 32'd0;
  endtask

  task automatic test_reset;
    idle_in();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #12;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.mem_req); end
    checks++; if (wb_we !== 1'b0 || fault !== 1'b0 || cause !== 2'b00 || wb_rd !== 5'd0)
      begin errors++; $display("FAIL reset_wb got we=%b f=%b c=%b rd=%0d want 0", wb_we, fault, cause, wb_rd); end
    checks++; if (bus.mem_wstrb !== 4'd0 || bus.mem_we !== 1'b0)
      begin errors++; $display("FAIL reset_bus got strb=%b we=%b want 0", bus.mem_wstrb, bus.mem_we); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_alu;
    drive(1'b0, 1'b0, 3'b000, 5'd5, 32'h0000_1234, 32'd0);
    tick();
    idle_in();
    checks++; if (wb_rd !== 5'd5 || wb_dat !== 32'h1234 || wb_we !== 1'b1)
      begin errors++; $display("FAIL alu_retire got rd=%0d dat=%h we=%b want 5 00001234 1", wb_rd, wb_dat, wb_we); end
    checks++; if (wb_inst !== 32'hC0DE_1234 || wb_pc !== 32'h8000_1234)
      begin errors++; $display("FAIL alu_inst got %h %h want c0de1234 80001234", wb_inst, wb_pc); end
    checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0)
      begin errors++; $display("FAIL alu_noreq got req=%b stall=%b want 0 0", bus.mem_req, stall); end
    tick();
    checks++; if (wb_we !== 1'b0 || wb_rd !== 5'd0)
      begin errors++; $display("FAIL alu_onecycle got we=%b rd=%0d want 0 0", wb_we, wb_rd); end
  endtask

  task automatic test_lb;
    int stall_cycles;
    stall_cycles = 0;
    drive(1'b1, 1'b0, 3'b000, 5'd7, 32'h0000_0103, 32'd0);
    tick();
    idle_in();
    if (stall === 1'b1) stall_cycles++;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0)
      begin errors++; $display("FAIL lb_req got req=%b addr=%h we=%b want 1 00000100 0", bus.mem_req, bus.mem_addr, bus.mem_we); end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    if (stall === 1'b1) stall_cycles++;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL lb_req_drop got %b want 0", bus.mem_req); end
    tick();
    if (stall === 1'b1) stall_cycles++;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h80FF_FFFF;
    tick();
    bus.mem_rvalid = 1'b0;
    if (stall === 1'b1) stall_cycles++;
    checks++; if (wb_dat !== 32'hFFFF_FF80 || wb_we !== 1'b1 || wb_rd !== 5'd7)
      begin errors++; $display("FAIL lb_data got %h we=%b rd=%0d want ffffff80 1 7", wb_dat, wb_we, wb_rd); end
    checks++; if (stall_cycles != 3) begin errors++; $display("FAIL lb_stall_cycles got %0d want 3", stall_cycles); end
    tick();
  endtask

  task automatic test_load_lanes;
    logic [2:0]  vf3 [5] = '{3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] va  [5] = '{32'h101, 32'h102, 32'h100, 32'h104, 32'h100};
    logic [31:0] vr  [5] = '{32'h1234_8056, 32'h8001_7FFF, 32'h1234_F00D, 32'hDEAD_BEEF, 32'h0000_007F};
    logic [31:0] vx  [5] = '{32'h0000_0080, 32'hFFFF_8001, 32'h0000_F00D, 32'hDEAD_BEEF, 32'h0000_007F};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, vf3[i], 5'd9, va[i], 32'd0);
      tick();
      idle_in();
      bus.mem_gnt = 1'b1;
      tick();
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = vr[i];
      tick();
      bus.mem_rvalid = 1'b0;
      checks++; if (wb_dat !== vx[i] || wb_we !== 1'b1)
        begin errors++; $display("FAIL load_lane%0d got %h we=%b want %h 1", i, wb_dat, wb_we, vx[i]); end
    end
  endtask

  task automatic test_stores;
    logic [2:0]  vf3 [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] va  [3] = '{32'h202, 32'h101, 32'h300};
    logic [31:0] vd  [3] = '{32'h0000_ABCD, 32'h1111_2255, 32'h0123_4567};
    logic [31:0] vma [3] = '{32'h200, 32'h100, 32'h300};
    logic [31:0] vw  [3] = '{32'hABCD_ABCD, 32'h5555_5555, 32'h0123_4567};
    logic [3:0]  vs  [3] = '{4'b1100, 4'b0010, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, vf3[i], 5'd3, va[i], vd[i]);
      tick();
      idle_in();
      checks++; if (bus.mem_addr !== vma[i] || bus.mem_wdata !== vw[i] || bus.mem_wstrb !== vs[i] || bus.mem_we !== 1'b1)
        begin errors++; $display("FAIL store%0d_bus got a=%h d=%h s=%b we=%b want %h %h %b 1",
                                 i, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_we, vma[i], vw[i], vs[i]); end
      bus.mem_gnt = 1'b1;
      tick();
      bus.mem_gnt = 1'b0;
      checks++; if (bus.mem_wdata !== 32'd0 || bus.mem_wstrb !== 4'd0 || bus.mem_we !== 1'b0)
        begin errors++; $display("FAIL store%0d_idlebus got d=%h s=%b we=%b want 0", i, bus.mem_wdata, bus.mem_wstrb, bus.mem_we); end
      bus.mem_rvalid = 1'b1;
      tick();
      bus.mem_rvalid = 1'b0;
      checks++; if (wb_we !== 1'b0 || fault !== 1'b0 || stall !== 1'b0 || wb_pc !== 32'h8000_0000 + va[i])
        begin errors++; $display("FAIL store%0d_retire got we=%b f=%b stall=%b pc=%h want 0 0 0", i, wb_we, fault, stall, wb_pc); end
    end
  endtask

  task automatic test_faults;
    logic        vr [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  vf [4] = '{3'b010, 3'b011, 3'b100, 3'b001};
    logic [31:0] va [4] = '{32'h101, 32'h100, 32'h100, 32'h203};
    logic [1:0]  vc [4] = '{2'b01, 2'b11, 2'b11, 2'b01};
    for (int i = 0; i < 4; i++) begin
      drive(vr[i], !vr[i], vf[i], 5'd11, va[i], 32'd0);
      tick();
      idle_in();
      checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0)
        begin errors++; $display("FAIL fault%0d_noreq got req=%b stall=%b want 0 0", i, bus.mem_req, stall); end
      checks++; if (fault !== 1'b1 || cause !== vc[i] || wb_we !== 1'b0 || wb_pc !== 32'h8000_0000 + va[i])
        begin errors++; $display("FAIL fault%0d got f=%b c=%b we=%b want 1 %b 0", i, fault, cause, wb_we, vc[i]); end
    end
    tick();
    checks++; if (fault !== 1'b0 || cause !== 2'b00)
      begin errors++; $display("FAIL fault_clear got f=%b c=%b want 0 00", fault, cause); end
  endtask

  task automatic test_read_priority;
    drive(1'b1, 1'b1, 3'b100, 5'd12, 32'h0000_0102, 32'hFFFF_FFFF);
    tick();
    idle_in();
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_wstrb !== 4'd0)
      begin errors++; $display("FAIL prio_req got req=%b we=%b s=%b want 1 0 0000", bus.mem_req, bus.mem_we, bus.mem_wstrb); end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00A5_0000;
    tick();
    bus.mem_rvalid = 1'b0;
    checks++; if (wb_dat !== 32'h0000_00A5 || wb_we !== 1'b1 || wb_rd !== 5'd12)
      begin errors++; $display("FAIL prio_data got %h we=%b rd=%0d want 000000a5 1 12", wb_dat, wb_we, wb_rd); end
  endtask

  task automatic test_timeout;
    // rvalid before grant must be ignored while in REQ.
    drive(1'b1, 1'b0, 3'b010, 5'd13, 32'h0000_0400, 32'd0);
    tick();
    idle_in();
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
    tick();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    checks++; if (wb_we !== 1'b0 || stall !== 1'b1)
      begin errors++; $display("FAIL tmo_rvalid_in_req got we=%b stall=%b want 0 1", wb_we, stall); end
    for (int i = 3; i <= 8; i++) begin
      tick();
      checks++; if (stall !== 1'b1 || fault !== 1'b0)
        begin errors++; $display("FAIL tmo_wait_cycle%0d got stall=%b f=%b want 1 0", i, stall, fault); end
    end
    tick();
    checks++; if (fault !== 1'b1 || cause !== 2'b10 || wb_we !== 1'b0 || stall !== 1'b0 || wb_rd !== 5'd13)
      begin errors++; $display("FAIL tmo_fault got f=%b c=%b we=%b stall=%b rd=%0d want 1 10 0 0 13", fault, cause, wb_we, stall, wb_rd); end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_rvalid = 1'b0;
    checks++; if (wb_we !== 1'b0 || fault !== 1'b0 || stall !== 1'b0 || bus.mem_req !== 1'b0)
      begin errors++; $display("FAIL tmo_late_rvalid got we=%b f=%b stall=%b req=%b want 0", wb_we, fault, stall, bus.mem_req); end
  endtask

  task automatic test_reset_inflight;
    // Reset while requesting: mem_req must drop without a clock edge.
    drive(1'b1, 1'b0, 3'b010, 5'd14, 32'h0000_0500, 32'd0);
    tick();
    idle_in();
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0)
      begin errors++; $display("FAIL rst_req_async got req=%b stall=%b want 0 0", bus.mem_req, stall); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    // Reset while waiting for data.
    drive(1'b1, 1'b0, 3'b010, 5'd15, 32'h0000_0600, 32'd0);
    tick();
    idle_in();
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_wait_pre got stall=%b want 1", stall); end
    #2 rst = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || bus.mem_req !== 1'b0)
      begin errors++; $display("FAIL rst_wait_async got stall=%b req=%b want 0 0", stall, bus.mem_req); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    bus.mem_rvalid = 1'b0;
    checks++; if (wb_we !== 1'b0 || fault !== 1'b0 || wb_rd !== 5'd0 || stall !== 1'b0)
      begin errors++; $display("FAIL rst_late_rvalid got we=%b f=%b rd=%0d stall=%b want 0", wb_we, fault, wb_rd, stall); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_load_lanes();
    test_stores();
    test_faults();
    test_read_priority();
    test_timeout();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
